// File: rtl/tcam_pipe_if.sv
// Request/response bus for tcam_pipe: valid/ready request channel and in-order response channel.
interface tcam_pipe_if #(
  parameter int KEY_WIDTH = 32,
  parameter int ADDR_W    = 4
);
  logic                 req_valid;
  logic                 req_ready;
  logic [1:0]           req_op;
  logic [KEY_WIDTH-1:0] req_key;
  logic [KEY_WIDTH-1:0] req_mask;
  logic [ADDR_W-1:0]    req_addr;

  logic                 resp_valid;
  logic                 resp_ready;
  logic [1:0]           resp_op;
  logic                 resp_hit;
  logic                 resp_multi;
  logic [ADDR_W-1:0]    resp_addr;
  logic [KEY_WIDTH-1:0] resp_key;
  logic [KEY_WIDTH-1:0] resp_mask;
  logic                 resp_evict;

  modport master (
    output req_valid, req_op, req_key, req_mask, req_addr, resp_ready,
    input  req_ready, resp_valid, resp_op, resp_hit, resp_multi,
           resp_addr, resp_key, resp_mask, resp_evict
  );

  modport slave (
    input  req_valid, req_op, req_key, req_mask, req_addr, resp_ready,
    output req_ready, resp_valid, resp_op, resp_hit, resp_multi,
           resp_addr, resp_key, resp_mask, resp_evict
  );
endinterface

// File: rtl/tcam_pipe.sv
// Ternary CAM with two-stage pipelined search, auto-allocating insert with round-robin
// eviction, write/delete by address, occupancy tracking and full-pipeline backpressure.
module tcam_pipe #(
  parameter int KEY_WIDTH = 32,
  parameter int KEY_DEPTH = 16,
  parameter int ADDR_W    = $clog2(KEY_DEPTH),
  parameter int CNT_W     = $clog2(KEY_DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  tcam_pipe_if.slave       bus,
  output logic [CNT_W-1:0] occupancy
);

  typedef enum logic [1:0] {
    OP_SEARCH = 2'b00,
    OP_INSERT = 2'b01,
    OP_WRITE  = 2'b10,
    OP_DELETE = 2'b11
  } op_e;

  logic [KEY_WIDTH-1:0] key_mem  [KEY_DEPTH];
  logic [KEY_WIDTH-1:0] mask_mem [KEY_DEPTH];
  logic [KEY_DEPTH-1:0] vld;
  logic [ADDR_W-1:0]    victim_ptr;

  logic                 stall;
  logic                 accept;
  op_e                  req_op;

  logic [KEY_DEPTH-1:0] match;
  logic                 full;
  logic [ADDR_W-1:0]    free_idx;
  logic [ADDR_W-1:0]    ins_addr;
  logic [ADDR_W-1:0]    tgt_addr;

  logic                 s1_valid;
  op_e                  s1_op;
  logic [ADDR_W-1:0]    s1_addr;
  logic                 s1_evict;
  logic [KEY_DEPTH-1:0] s1_match;

  logic                 s2_hit;
  logic                 s2_multi;
  logic [ADDR_W-1:0]    win_idx;

  assign stall         = bus.resp_valid & ~bus.resp_ready;
  assign bus.req_ready = ~stall;
  assign accept        = bus.req_valid & ~stall;
  assign req_op        = op_e'(bus.req_op);
  assign full          = &vld;
  assign ins_addr      = full ? victim_ptr : free_idx;
  assign tgt_addr      = (req_op == OP_INSERT) ? ins_addr : bus.req_addr;

  // Stage 1 compare against the table as it stands in the accept cycle.
  always_comb begin
    match = '0;
    for (int unsigned i = 0; i < KEY_DEPTH; i++) begin
      match[i] = vld[i] && (((bus.req_key ^ key_mem[i]) & mask_mem[i]) == '0);
    end
  end

  always_comb begin
    logic found;
    found    = 1'b0;
    free_idx = '0;
    for (int unsigned i = 0; i < KEY_DEPTH; i++) begin
      if (!found && !vld[i]) begin
        free_idx = ADDR_W'(i);
        found    = 1'b1;
      end
    end
  end

  always_comb begin
    logic found;
    found   = 1'b0;
    win_idx = '0;
    for (int unsigned i = 0; i < KEY_DEPTH; i++) begin
      if (!found && s1_match[i]) begin
        win_idx = ADDR_W'(i);
        found   = 1'b1;
      end
    end
    s2_hit   = |s1_match;
    s2_multi = |(s1_match & (s1_match - KEY_DEPTH'(1)));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_op    <= OP_SEARCH;
      s1_addr  <= '0;
      s1_evict <= 1'b0;
      s1_match <= '0;
    end else if (!stall) begin
      s1_valid <= accept;
      s1_op    <= req_op;
      s1_addr  <= tgt_addr;
      s1_evict <= accept && (req_op == OP_INSERT) && full;
      s1_match <= (accept && req_op == OP_SEARCH) ? match : '0;
    end
  end

  // Stage 2 reads key/mask of the winner; the table cannot change between
  // the compare and this read because every accept also advances stage 1.
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.resp_valid <= 1'b0;
      bus.resp_op    <= '0;
      bus.resp_hit   <= 1'b0;
      bus.resp_multi <= 1'b0;
      bus.resp_addr  <= '0;
      bus.resp_key   <= '0;
      bus.resp_mask  <= '0;
      bus.resp_evict <= 1'b0;
    end else if (!stall) begin
      bus.resp_valid <= s1_valid;
      bus.resp_op    <= s1_valid ? s1_op : OP_SEARCH;
      bus.resp_hit   <= s1_valid & s2_hit;
      bus.resp_multi <= s1_valid & s2_multi;
      bus.resp_evict <= s1_valid & s1_evict;
      if (!s1_valid)
        bus.resp_addr <= '0;
      else if (s1_op == OP_SEARCH)
        bus.resp_addr <= win_idx;
      else
        bus.resp_addr <= s1_addr;
      bus.resp_key   <= (s1_valid && s2_hit) ? key_mem[win_idx]  : '0;
      bus.resp_mask  <= (s1_valid && s2_hit) ? mask_mem[win_idx] : '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld        <= '0;
      victim_ptr <= '0;
      occupancy  <= '0;
    end else if (accept) begin
      unique case (req_op)
        OP_INSERT: begin
          vld[ins_addr] <= 1'b1;
          if (full) victim_ptr <= victim_ptr + ADDR_W'(1);
          else      occupancy  <= occupancy + CNT_W'(1);
        end
        OP_WRITE: begin
          vld[bus.req_addr] <= 1'b1;
          if (!vld[bus.req_addr]) occupancy <= occupancy + CNT_W'(1);
        end
        OP_DELETE: begin
          vld[bus.req_addr] <= 1'b0;
          if (vld[bus.req_addr]) occupancy <= occupancy - CNT_W'(1);
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (accept && (req_op == OP_INSERT || req_op == OP_WRITE)) begin
      key_mem[tgt_addr]  <= bus.req_key;
      mask_mem[tgt_addr] <= bus.req_mask;
    end
  end

endmodule

// File: tb/tb_tcam_pipe.sv
// Self-checking bench for tcam_pipe: table-driven single-op vectors with a response
// scoreboard, plus stall-stream and reset-in-flight sequences.
module tb_tcam_pipe;
  localparam int KW = 32;
  localparam int KD = 16;
  localparam int AW = 4;
  localparam int CW = 5;

  localparam logic [1:0] SRCH = 2'b00;
  localparam logic [1:0] INS  = 2'b01;
  localparam logic [1:0] WR   = 2'b10;
  localparam logic [1:0] DEL  = 2'b11;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [CW-1:0] occupancy;

  always #5 clk = ~clk;

  tcam_pipe_if #(.KEY_WIDTH(KW), .ADDR_W(AW)) bus ();

  tcam_pipe #(.KEY_WIDTH(KW), .KEY_DEPTH(KD)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .occupancy (occupancy)
  );

  typedef struct {
    logic [1:0]    op;
    logic [KW-1:0] key;
    logic [KW-1:0] mask;
    logic [AW-1:0] addr;
    logic          hit;
    logic          multi;
    logic [AW-1:0] raddr;
    logic [KW-1:0] rkey;
    logic [KW-1:0] rmask;
    logic          evict;
    logic [CW-1:0] occ;
  } vec_t;

  typedef struct {
    logic [1:0]    op;
    logic          hit;
    logic          multi;
    logic [AW-1:0] raddr;
    logic [KW-1:0] rkey;
    logic [KW-1:0] rmask;
    logic          evict;
    int            acc;
    bit            lat;
  } exp_t;

  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  exp_t sb[$];
  vec_t vq[$];

  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic vec_t mk(input logic [1:0] op, input logic [KW-1:0] key, input logic [KW-1:0] mask,
                              input logic [AW-1:0] addr, input logic hit, input logic multi,
                              input logic [AW-1:0] raddr, input logic [KW-1:0] rkey,
                              input logic [KW-1:0] rmask, input logic evict, input logic [CW-1:0] occ);
    vec_t v;
    v.op = op; v.key = key; v.mask = mask; v.addr = addr;
    v.hit = hit; v.multi = multi; v.raddr = raddr; v.rkey = rkey; v.rmask = rmask;
    v.evict = evict; v.occ = occ;
    return v;
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (bus.resp_valid && bus.resp_ready) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_resp: got resp_valid=1 op=%0d addr=%0d required no response", bus.resp_op, bus.resp_addr);
      end else begin
        e = sb.pop_front();
        chk("resp_op",    bus.resp_op,    e.op);
        chk("resp_hit",   bus.resp_hit,   e.hit);
        chk("resp_multi", bus.resp_multi, e.multi);
        chk("resp_addr",  bus.resp_addr,  e.raddr);
        chk("resp_key",   bus.resp_key,   e.rkey);
        chk("resp_mask",  bus.resp_mask,  e.rmask);
        chk("resp_evict", bus.resp_evict, e.evict);
        if (e.lat) chk("latency", 64'(cyc - e.acc), 64'd2);
      end
    end
  end

  task automatic issue(input vec_t v, input bit lat);
    exp_t e;
    bit   ok;
    ok = 1'b0;
    bus.req_valid = 1'b1;
    bus.req_op    = v.op;
    bus.req_key   = v.key;
    bus.req_mask  = v.mask;
    bus.req_addr  = v.addr;
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      if (bus.req_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      total++;
      bad++;
      $display("FAIL accept_timeout: got req_ready=0 for 100 cycles required 1");
    end else begin
      e.op = v.op; e.hit = v.hit; e.multi = v.multi; e.raddr = v.raddr;
      e.rkey = v.rkey; e.rmask = v.rmask; e.evict = v.evict; e.acc = cyc; e.lat = lat;
      sb.push_back(e);
    end
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    if (sb.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain_timeout: got %0d pending responses required 0", sb.size());
      sb.delete();
    end
  endtask

  initial begin
    vec_t v;

    vq.push_back(mk(WR,   32'hDEADBEEF, 32'hFFFFFFFF, 4'd3, 0, 0, 4'd3, '0, '0, 0, 5'd1));
    vq.push_back(mk(SRCH, 32'hDEADBEEF, 32'h0,        4'd0, 1, 0, 4'd3, 32'hDEADBEEF, 32'hFFFFFFFF, 0, 5'd1));
    vq.push_back(mk(WR,   32'h12340000, 32'hFFFF0000, 4'd5, 0, 0, 4'd5, '0, '0, 0, 5'd2));
    vq.push_back(mk(WR,   32'h12345678, 32'hFFFFFFFF, 4'd2, 0, 0, 4'd2, '0, '0, 0, 5'd3));
    vq.push_back(mk(SRCH, 32'h12345678, 32'h0,        4'd0, 1, 1, 4'd2, 32'h12345678, 32'hFFFFFFFF, 0, 5'd3));
    vq.push_back(mk(SRCH, 32'h1234ABCD, 32'h0,        4'd0, 1, 0, 4'd5, 32'h12340000, 32'hFFFF0000, 0, 5'd3));
    vq.push_back(mk(SRCH, 32'h00000000, 32'h0,        4'd0, 0, 0, 4'd0, '0, '0, 0, 5'd3));
    vq.push_back(mk(DEL,  32'h0, 32'h0, 4'd3, 0, 0, 4'd3, '0, '0, 0, 5'd2));
    vq.push_back(mk(DEL,  32'h0, 32'h0, 4'd5, 0, 0, 4'd5, '0, '0, 0, 5'd1));
    vq.push_back(mk(DEL,  32'h0, 32'h0, 4'd2, 0, 0, 4'd2, '0, '0, 0, 5'd0));
    for (int i = 0; i < KD; i++)
      vq.push_back(mk(INS, 32'hA0000000 + i, 32'hFFFFFFFF, 4'd0, 0, 0, AW'(i), '0, '0, 0, CW'(i + 1)));
    vq.push_back(mk(INS,  32'hB0000000, 32'hFFFFFFFF, 4'd0, 0, 0, 4'd0, '0, '0, 1, 5'd16));
    vq.push_back(mk(INS,  32'hB0000001, 32'hFFFFFFFF, 4'd0, 0, 0, 4'd1, '0, '0, 1, 5'd16));
    vq.push_back(mk(DEL,  32'h0, 32'h0, 4'd7, 0, 0, 4'd7, '0, '0, 0, 5'd15));
    vq.push_back(mk(DEL,  32'h0, 32'h0, 4'd7, 0, 0, 4'd7, '0, '0, 0, 5'd15));
    vq.push_back(mk(INS,  32'hC0000007, 32'hFFFFFFFF, 4'd0, 0, 0, 4'd7, '0, '0, 0, 5'd16));
    vq.push_back(mk(WR,   32'h00000000, 32'h00000000, 4'd15, 0, 0, 4'd15, '0, '0, 0, 5'd16));
    vq.push_back(mk(SRCH, 32'h12345678, 32'h0, 4'd0, 1, 0, 4'd15, 32'h0, 32'h0, 0, 5'd16));
    vq.push_back(mk(SRCH, 32'hA0000003, 32'h0, 4'd0, 1, 1, 4'd3, 32'hA0000003, 32'hFFFFFFFF, 0, 5'd16));

    bus.req_valid  = 1'b0;
    bus.req_op     = '0;
    bus.req_key    = '0;
    bus.req_mask   = '0;
    bus.req_addr   = '0;
    bus.resp_ready = 1'b0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_resp_valid", bus.resp_valid, 1'b0);
    chk("reset_req_ready",  bus.req_ready,  1'b1);
    chk("reset_occupancy",  occupancy,      5'd0);
    chk("reset_resp_addr",  bus.resp_addr,  4'd0);
    chk("reset_resp_hit",   bus.resp_hit,   1'b0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    bus.resp_ready = 1'b1;

    for (int i = 0; i < vq.size(); i++) begin
      issue(vq[i], 1'b1);
      drain();
      chk("occupancy", occupancy, vq[i].occ);
      @(posedge clk);
      #1;
    end

    // Back-to-back searches with the response side held off for three cycles.
    vq.delete();
    vq.push_back(mk(SRCH, 32'hA0000002, '0, '0, 1, 1, 4'd2,  32'hA0000002, 32'hFFFFFFFF, 0, '0));
    vq.push_back(mk(SRCH, 32'hA0000003, '0, '0, 1, 1, 4'd3,  32'hA0000003, 32'hFFFFFFFF, 0, '0));
    vq.push_back(mk(SRCH, 32'hA0000004, '0, '0, 1, 1, 4'd4,  32'hA0000004, 32'hFFFFFFFF, 0, '0));
    vq.push_back(mk(SRCH, 32'hA0000005, '0, '0, 1, 1, 4'd5,  32'hA0000005, 32'hFFFFFFFF, 0, '0));
    vq.push_back(mk(SRCH, 32'hA0000006, '0, '0, 1, 1, 4'd6,  32'hA0000006, 32'hFFFFFFFF, 0, '0));
    vq.push_back(mk(SRCH, 32'hFFFFFFFF, '0, '0, 1, 0, 4'd15, 32'h0,        32'h0,        0, '0));
    vq.push_back(mk(SRCH, 32'hB0000001, '0, '0, 1, 1, 4'd1,  32'hB0000001, 32'hFFFFFFFF, 0, '0));
    vq.push_back(mk(SRCH, 32'hC0000007, '0, '0, 1, 1, 4'd7,  32'hC0000007, 32'hFFFFFFFF, 0, '0));
    vq.push_back(mk(SRCH, 32'hA000000E, '0, '0, 1, 1, 4'd14, 32'hA000000E, 32'hFFFFFFFF, 0, '0));
    fork
      begin
        for (int i = 0; i < vq.size(); i++) issue(vq[i], 1'b0);
      end
      begin
        repeat (4) @(posedge clk);
        #1;
        bus.resp_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
          @(negedge clk);
          chk("stall_req_ready", bus.req_ready, 1'b0);
          chk("stall_resp_valid", bus.resp_valid, 1'b1);
        end
        @(posedge clk);
        #1;
        bus.resp_ready = 1'b1;
      end
    join
    drain();
    chk("stream_occupancy", occupancy, 5'd16);

    // Reset with two searches in flight: both must vanish and the table must empty.
    @(posedge clk);
    #1;
    bus.resp_ready = 1'b0;
    issue(mk(SRCH, 32'hA0000003, '0, '0, 1, 1, 4'd3, 32'hA0000003, 32'hFFFFFFFF, 0, '0), 1'b0);
    issue(mk(SRCH, 32'hA0000004, '0, '0, 1, 1, 4'd4, 32'hA0000004, 32'hFFFFFFFF, 0, '0), 1'b0);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_resp_valid", bus.resp_valid, 1'b0);
    chk("rst_req_ready",  bus.req_ready,  1'b1);
    chk("rst_occupancy",  occupancy,      5'd0);
    sb.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    bus.resp_ready = 1'b1;
    repeat (4) @(negedge clk);
    chk("post_rst_idle", bus.resp_valid, 1'b0);
    @(posedge clk);
    #1;
    issue(mk(SRCH, 32'hA0000003, '0, '0, 0, 0, 4'd0, '0, '0, 0, '0), 1'b1);
    drain();
    chk("post_rst_occupancy", occupancy, 5'd0);
    repeat (5) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
